// File: rtl/tdes_pkg.sv
// Shared types and constants for the 3DES round sequencer.
package tdes_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        ROUND    = 3'd2,
        PASS_END = 3'd3,
        DONE     = 3'd4
    } seq_state_t;

    localparam logic [1:0] KEY_K1 = 2'd0;
    localparam logic [1:0] KEY_K2 = 2'd1;
    localparam logic [1:0] KEY_K3 = 2'd2;

    localparam int DES_ROUNDS = 16;

    // Index of the final pass of an EDE operation.
    localparam logic [1:0] LAST_PASS_3DES = 2'd2;

    // Key used in a given pass. EDE encrypt walks K1,K2,K3; decrypt walks K3,K2,K1.
    function automatic logic [1:0] pass_key(input logic [1:0] pass,
                                            input logic       dec,
                                            input logic       single);
        logic [1:0] key;
        if (single) begin
            key = KEY_K1;
        end else begin
            case (pass)
                2'd0:    key = dec ? KEY_K3 : KEY_K1;
                2'd1:    key = KEY_K2;
                2'd2:    key = dec ? KEY_K1 : KEY_K3;
                default: key = KEY_K1;
            endcase
        end
        return key;
    endfunction

    // Direction of a pass: the middle EDE pass runs opposite to the requested direction.
    function automatic logic pass_dir(input logic [1:0] pass, input logic dec);
        return dec ^ pass[0];
    endfunction

endpackage

// File: rtl/flex_counter.sv
// Generic up-counter with synchronous clear, enable and programmable rollover.
// rollover_flag is registered and is high while count_out equals rollover_val.
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag
);

    logic [NUM_CNT_BITS-1:0] count_q, count_d;
    logic                    flag_q, flag_d;

    // Next count: clear wins, then increment with wrap to 1 after rollover_val.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_enable) begin
            if (count_q == rollover_val) begin
                count_d = NUM_CNT_BITS'(1);
            end else begin
                count_d = count_q + NUM_CNT_BITS'(1);
            end
        end else begin
            count_d = count_q;
        end
        flag_d = (count_d == rollover_val);
    end

    // Count and flag registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
            flag_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            flag_q  <= flag_d;
        end
    end

    assign count_out     = count_q;
    assign rollover_flag = flag_q;

endmodule

// File: rtl/tdes_round_sequencer.sv
// Control FSM for the 3DES core: LOAD, 16 rounds per DES pass, 1 or 3 passes (EDE).
// The round counter holds the zero-based round index of the current pass; its
// rollover is set at the last index so the pass ends after exactly NUM_ROUNDS rounds.
module tdes_round_sequencer
    import tdes_pkg::*;
#(
    parameter int NUM_ROUNDS     = DES_ROUNDS,
    parameter int ROUND_CNT_BITS = 5
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       start,
    input  logic       decrypt,
    input  logic       single_des,
    output logic       busy,
    output logic       load_data,
    output logic       round_en,
    output logic [3:0] round_idx,
    output logic [3:0] subkey_idx,
    output logic [1:0] key_sel,
    output logic       pass_dec,
    output logic       pass_done,
    output logic       done
);

    seq_state_t state_q, state_d;
    logic [1:0] pass_q, pass_d;
    logic       dec_q, dec_d;
    logic       single_q, single_d;

    logic                      cnt_clear_s;
    logic                      cnt_en_s;
    logic [ROUND_CNT_BITS-1:0] count_s;
    logic                      rollover_s;
    logic                      last_pass_s;
    logic                      dir_s;
    logic [1:0]                key_s;
    logic [3:0]                idx_s;
    logic                      cnt_unused_s;

    assign cnt_clear_s  = (state_q == LOAD) || (state_q == PASS_END);
    assign cnt_en_s     = (state_q == ROUND) && !rollover_s;
    assign last_pass_s  = single_q ? (pass_q == 2'd0) : (pass_q == LAST_PASS_3DES);
    assign dir_s        = pass_dir(pass_q, dec_q);
    assign key_s        = pass_key(pass_q, dec_q, single_q);
    assign idx_s        = count_s[3:0];
    assign cnt_unused_s = ^count_s[ROUND_CNT_BITS-1:4];

    flex_counter #(
        .NUM_CNT_BITS(ROUND_CNT_BITS)
    ) u_round_cnt (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (cnt_clear_s),
        .count_enable (cnt_en_s),
        .rollover_val (ROUND_CNT_BITS'(NUM_ROUNDS - 1)),
        .count_out    (count_s),
        .rollover_flag(rollover_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     state_d = start ? LOAD : IDLE;
            LOAD:     state_d = ROUND;
            ROUND: begin
                if (rollover_s) begin
                    state_d = last_pass_s ? DONE : PASS_END;
                end else begin
                    state_d = ROUND;
                end
            end
            PASS_END: state_d = ROUND;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Mode latches capture the request in IDLE; pass counter restarts on LOAD and steps on PASS_END.
    always_comb begin
        pass_d   = pass_q;
        dec_d    = dec_q;
        single_d = single_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    dec_d    = decrypt;
                    single_d = single_des;
                end else begin
                    dec_d    = dec_q;
                    single_d = single_q;
                end
            end
            LOAD:     pass_d = 2'd0;
            PASS_END: pass_d = pass_q + 2'd1;
            default:  pass_d = pass_q;
        endcase
    end

    // Pass counter and latched mode registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pass_q   <= 2'd0;
            dec_q    <= 1'b0;
            single_q <= 1'b0;
        end else begin
            pass_q   <= pass_d;
            dec_q    <= dec_d;
            single_q <= single_d;
        end
    end

    // Output decode from registered state, round counter and latched mode.
    always_comb begin
        busy       = 1'b0;
        load_data  = 1'b0;
        round_en   = 1'b0;
        round_idx  = 4'd0;
        subkey_idx = 4'd0;
        key_sel    = 2'd0;
        pass_dec   = 1'b0;
        pass_done  = 1'b0;
        done       = 1'b0;
        case (state_q)
            IDLE: busy = 1'b0;
            LOAD: begin
                busy      = 1'b1;
                load_data = 1'b1;
            end
            ROUND: begin
                busy       = 1'b1;
                round_en   = 1'b1;
                round_idx  = idx_s;
                subkey_idx = dir_s ? (4'd15 - idx_s) : idx_s;
                key_sel    = key_s;
                pass_dec   = dir_s;
            end
            PASS_END: begin
                busy      = 1'b1;
                pass_done = 1'b1;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: busy = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_tdes_round_sequencer.sv
// Self-checking bench: cycle-by-cycle comparison against a timeline model of the sequencer.
module tb_tdes_round_sequencer;

    logic       clk = 1'b0;
    logic       n_rst, start, decrypt, single_des;
    logic       busy, load_data, round_en, pass_dec, pass_done, done;
    logic [3:0] round_idx, subkey_idx;
    logic [1:0] key_sel;
    logic [15:0] dut_v;

    int total = 0;
    int bad   = 0;

    // Reference model: mk = cycle offset within an operation (0 = idle, 1 = LOAD cycle).
    int mk = 0;
    bit mdec = 1'b0;
    bit msgl = 1'b0;

    int cyc, n_round, n_done, n_pdone, n_load;

    always #5 clk = ~clk;

    tdes_round_sequencer dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .start     (start),
        .decrypt   (decrypt),
        .single_des(single_des),
        .busy      (busy),
        .load_data (load_data),
        .round_en  (round_en),
        .round_idx (round_idx),
        .subkey_idx(subkey_idx),
        .key_sel   (key_sel),
        .pass_dec  (pass_dec),
        .pass_done (pass_done),
        .done      (done)
    );

    assign dut_v = {busy, load_data, round_en, round_idx, subkey_idx, key_sel, pass_dec, pass_done, done};

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected output vector for cycle offset k of an operation with the given mode.
    // Timeline: LOAD at 1, pass p rounds at 2+17p..17+17p, PASS_END at 18+17p, DONE at 17*passes+1.
    function automatic logic [15:0] expv(input int k, input bit dec, input bit sgl);
        int np;
        int last;
        int r;
        int p;
        int i;
        bit dir;
        logic [1:0] key;
        logic [3:0] idx;
        logic [3:0] sk;
        np   = sgl ? 1 : 3;
        last = 17 * np + 1;
        if (k == 0) return 16'h0000;
        if (k == 1) return {1'b1, 1'b1, 14'b0};
        if (k == last) return {1'b1, 14'b0, 1'b1};
        r = k - 2;
        p = r / 17;
        i = r % 17;
        if (i == 16) return {1'b1, 13'b0, 1'b1, 1'b0};
        if (sgl) dir = dec;
        else     dir = (p == 1) ? !dec : dec;
        if (sgl)      key = 2'd0;
        else if (dec) key = 2'(2 - p);
        else          key = 2'(p);
        idx = 4'(i);
        sk  = dir ? 4'(15 - i) : 4'(i);
        return {1'b1, 1'b0, 1'b1, idx, sk, key, dir, 1'b0, 1'b0};
    endfunction

    task automatic model_step();
        int last;
        last = 17 * (msgl ? 1 : 3) + 1;
        if (!n_rst) begin
            mk = 0;
        end else if (mk == 0) begin
            if (start) begin
                mk   = 1;
                mdec = decrypt;
                msgl = single_des;
            end
        end else if (mk == last) begin
            mk = 0;
        end else begin
            mk++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk_eq("cyc", 32'(dut_v), 32'(expv(mk, mdec, msgl)));
        cyc++;
        if (round_en)  n_round++;
        if (done)      n_done++;
        if (pass_done) n_pdone++;
        if (load_data) n_load++;
    endtask

    task automatic clear_stats();
        cyc = 0; n_round = 0; n_done = 0; n_pdone = 0; n_load = 0;
    endtask

    // Called just after a negedge sample: assert reset away from the clock edge.
    task automatic async_reset();
        n_rst = 1'b0;
        #1;
        mk = 0;
        chk_eq("rst_async", 32'(dut_v), 32'h0);
        tick();
        n_rst = 1'b1;
    endtask

    task automatic run_op(input bit dec, input bit sgl, input int exp_lat);
        int done_c;
        int np;
        np = sgl ? 1 : 3;
        done_c = 0;
        start = 1'b1; decrypt = dec; single_des = sgl;
        clear_stats();
        for (int c = 1; c <= 100 && done_c == 0; c++) begin
            tick();
            start      = 1'b0;
            decrypt    = 1'($urandom);
            single_des = 1'($urandom);
            if (done) done_c = c;
        end
        chk_eq("latency", 32'(done_c), 32'(exp_lat));
        chk_eq("rounds", 32'(n_round), 32'(16 * np));
        chk_eq("pass_done_cnt", 32'(n_pdone), 32'(np - 1));
        tick();
        chk_eq("busy_after", 32'(busy), 32'h0);
    endtask

    initial begin
        int l1;
        int l2;
        n_rst = 1'b1; start = 1'b0; decrypt = 1'b0; single_des = 1'b0;
        clear_stats();

        // 1: reset and idle
        #2;
        n_rst = 1'b0;
        #1;
        chk_eq("rst_outs", 32'(dut_v), 32'h0);
        tick();
        tick();
        n_rst = 1'b1;
        clear_stats();
        for (int i = 0; i < 5; i++) tick();
        chk_eq("idle_pulses", 32'(n_load + n_done + n_pdone + n_round), 32'h0);
        chk_eq("idle_busy", 32'(busy), 32'h0);

        // 2-4: encrypt, decrypt, single DES
        run_op(1'b0, 1'b0, 52);
        run_op(1'b1, 1'b0, 52);
        run_op(1'b1, 1'b1, 18);
        run_op(1'b0, 1'b1, 18);

        // 5a: start pulsed while busy is ignored
        start = 1'b1; decrypt = 1'b0; single_des = 1'b0;
        clear_stats();
        tick();
        start = 1'b0;
        for (int c = 2; c <= 60; c++) begin
            tick();
            start = (cyc == 19);
        end
        start = 1'b0;
        chk_eq("busy_start_done", 32'(n_done), 32'h1);
        chk_eq("busy_start_load", 32'(n_load), 32'h1);

        // 5b: start held high gives back-to-back operations
        start = 1'b1; decrypt = 1'b1; single_des = 1'b0;
        clear_stats();
        l1 = 0; l2 = 0;
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (load_data) begin
                if (l1 == 0) l1 = cyc;
                else if (l2 == 0) l2 = cyc;
            end
        end
        start = 1'b0;
        chk_eq("held_load1", 32'(l1), 32'h1);
        chk_eq("held_load2", 32'(l2), 32'd54);
        for (int c = 0; c < 60 && busy; c++) tick();
        chk_eq("held_drain", 32'(busy), 32'h0);

        // 6: reset mid-operation, then a normal operation
        start = 1'b1; decrypt = 1'b0; single_des = 1'b0;
        clear_stats();
        tick();
        start = 1'b0;
        while (cyc < 30) tick();
        async_reset();
        clear_stats();
        for (int c = 0; c < 60; c++) tick();
        chk_eq("rst_no_done", 32'(n_done), 32'h0);
        run_op(1'b0, 1'b0, 52);

        // Random traffic checked every cycle against the model
        clear_stats();
        for (int c = 0; c < 1500; c++) begin
            start      = ($urandom_range(0, 19) == 0);
            decrypt    = 1'($urandom);
            single_des = 1'($urandom);
            if ($urandom_range(0, 299) == 0) async_reset();
            else tick();
        end
        chk_eq("rand_activity", 32'(n_done > 0), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
